// File: rtl/regfile_mp_server.sv
// ============================================================================
// regfile_mp_server: bundled register-file responder, narrow read/write core
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_server #(
    parameter int NREG    = 64,
    parameter int AW      = 6,
    parameter int DW      = 32,
    parameter int NRD     = 4,
    parameter int NWR     = 2,
    parameter int PHYS_RD = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NRD*DW-1:0] rsp_data,
    output logic [7:0]        dbg_led
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [NRD-1:0]    rd_pend_q,  rd_pend_d;
    logic [NRD*AW-1:0] rd_addr_q,  rd_addr_d;
    logic [NWR-1:0]    wr_pend_q,  wr_pend_d;
    logic [NWR*AW-1:0] wr_addr_q,  wr_addr_d;
    logic [NWR*DW-1:0] wr_data_q,  wr_data_d;
    logic [NRD*DW-1:0] rsp_data_q, rsp_data_d;
    logic [7:0]        dbg_led_q,  dbg_led_d;
    logic [DW-1:0]     regfile_q [NREG];
    logic [DW-1:0]     regfile_d [NREG];

    logic accept;
    int unsigned served;
    logic wr_found;

    assign accept = req_valid && (state_q == S_IDLE);

    // Datapath: pending-lane masks shrink as lanes are served; reads all
    // complete before any write, which gives read-old ordering for free.
    always_comb begin
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        wr_pend_d  = wr_pend_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rsp_data_d = rsp_data_q;
        dbg_led_d  = dbg_led_q;
        regfile_d  = regfile_q;
        served     = 0;
        wr_found   = 1'b0;

        if (accept) begin
            rd_pend_d  = rd_en;
            rd_addr_d  = rd_addr;
            wr_pend_d  = wr_en;
            wr_addr_d  = wr_addr;
            wr_data_d  = wr_data;
            rsp_data_d = '0;
        end

        if (state_q == S_READ) begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_pend_q[i] && (served < PHYS_RD)) begin
                    rsp_data_d[i*DW +: DW] = regfile_q[rd_addr_q[i*AW +: AW]];
                    rd_pend_d[i]           = 1'b0;
                    served                 = served + 1;
                end
            end
        end

        if (state_q == S_WRITE) begin
            for (int j = 0; j < NWR; j++) begin
                if (!wr_found && wr_pend_q[j]) begin
                    wr_found                             = 1'b1;
                    wr_pend_d[j]                         = 1'b0;
                    regfile_d[wr_addr_q[j*AW +: AW]]     = wr_data_q[j*DW +: DW];
                    dbg_led_d                            = wr_data_q[j*DW +: 8];
                end
            end
        end
    end

    // DECODE spends one cycle after capture so that the routing decision is
    // made from registered enables.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (|rd_pend_q) begin
                    state_d = S_READ;
                end else if (|wr_pend_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_READ: begin
                if (rd_pend_d == '0) begin
                    state_d = (|wr_pend_q) ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                if (wr_pend_d == '0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rd_pend_q  <= '0;
            rd_addr_q  <= '0;
            wr_pend_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rsp_data_q <= '0;
            dbg_led_q  <= '0;
            for (int k = 0; k < NREG; k++) begin
                regfile_q[k] <= DW'(k);
            end
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rsp_data_q <= rsp_data_d;
            dbg_led_q  <= dbg_led_d;
            regfile_q  <= regfile_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign dbg_led   = dbg_led_q;

endmodule

`default_nettype wire
